// File: rtl/accel_sequencer.sv
// Command front-end for the modular-arithmetic accelerator: validates a command, runs the
// Montgomery R-setup pass when the cached modulant differs, waits for finished, returns a response.
module accel_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [DATA_WIDTH-1:0] cmd_mod,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic [DATA_WIDTH-1:0] acc_modulant,
  output logic [2:0]            acc_control,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_result,
  input  logic                  acc_finished,
  output logic                  busy
);

  localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]            OP_RSETUP = 3'b011;
  localparam logic [2:0]            OP_NONE   = 3'b000;
  localparam logic [DATA_WIDTH-1:0] ZERO      = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RS_ISSUE  = 3'd1,
    RS_SETTLE = 3'd2,
    RS_WAIT   = 3'd3,
    ISSUE     = 3'd4,
    SETTLE    = 3'd5,
    WAIT      = 3'd6,
    RESP      = 3'd7
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [2:0]            op;
  logic [2:0]            op_next;
  logic                  r_valid;
  logic                  r_valid_next;
  logic [DATA_WIDTH-1:0] r_mod;
  logic [DATA_WIDTH-1:0] r_mod_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [DATA_WIDTH-1:0] resp_data_next;
  logic                  resp_err_next;
  logic                  load_cmd;
  logic [2:0]            control_next;

  // Opcodes 110/111 do not exist; R setup, mult and exp need an odd modulant.
  function automatic logic cmd_illegal(input logic [2:0] opc, input logic [DATA_WIDTH-1:0] m);
    logic bad_op;
    logic needs_odd;
    bad_op    = opc[2] & opc[1];
    needs_odd = (opc == OP_RSETUP) | opc[2];
    return bad_op | (m == ZERO) | (needs_odd & ~m[0]);
  endfunction

  // Next-state, response capture, Montgomery cache and timeout counter.
  always_comb begin
    state_next     = state;
    op_next        = op;
    r_valid_next   = r_valid;
    r_mod_next     = r_mod;
    cnt_next       = wait_cnt;
    resp_data_next = resp_data;
    resp_err_next  = resp_err;
    load_cmd       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          op_next  = cmd_op;
          if (cmd_illegal(cmd_op, cmd_mod)) begin
            state_next     = RESP;
            resp_data_next = ZERO;
            resp_err_next  = 1'b1;
          end else if (cmd_op[2] && !(r_valid && (r_mod == cmd_mod))) begin
            state_next = RS_ISSUE;
          end else begin
            state_next = ISSUE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RS_ISSUE:  state_next = RS_SETTLE;
      RS_SETTLE: begin
        state_next = RS_WAIT;
        cnt_next   = CNT_ZERO;
      end
      RS_WAIT: begin
        if (acc_finished) begin
          state_next   = ISSUE;
          r_valid_next = 1'b1;
          r_mod_next   = acc_modulant;
        end else if (wait_cnt == CNT_LAST) begin
          state_next     = RESP;
          resp_data_next = ZERO;
          resp_err_next  = 1'b1;
          r_valid_next   = 1'b0;
        end else begin
          cnt_next = wait_cnt + CNT_ONE;
        end
      end
      ISSUE:  state_next = SETTLE;
      SETTLE: begin
        // finished may still be high from the previous operation here
        state_next = WAIT;
        cnt_next   = CNT_ZERO;
      end
      WAIT: begin
        if (acc_finished) begin
          state_next    = RESP;
          resp_err_next = 1'b0;
          if (op == OP_RSETUP) begin
            resp_data_next = ONE;
            r_valid_next   = 1'b1;
            r_mod_next     = acc_modulant;
          end else begin
            resp_data_next = acc_result;
          end
        end else if (wait_cnt == CNT_LAST) begin
          state_next     = RESP;
          resp_data_next = ZERO;
          resp_err_next  = 1'b1;
          r_valid_next   = 1'b0;
        end else begin
          cnt_next = wait_cnt + CNT_ONE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accelerator control for the state being entered, so the output can be registered.
  always_comb begin
    control_next = OP_NONE;
    case (state_next)
      RS_ISSUE, RS_SETTLE, RS_WAIT: control_next = OP_RSETUP;
      ISSUE, SETTLE, WAIT:          control_next = op_next;
      default:                      control_next = OP_NONE;
    endcase
  end

  // State, cache, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op           <= OP_NONE;
      r_valid      <= 1'b0;
      r_mod        <= ZERO;
      wait_cnt     <= CNT_ZERO;
      resp_data    <= ZERO;
      resp_err     <= 1'b0;
      acc_a        <= ZERO;
      acc_b        <= ZERO;
      acc_modulant <= ZERO;
      acc_control  <= OP_NONE;
      acc_start    <= 1'b0;
      cmd_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      op           <= op_next;
      r_valid      <= r_valid_next;
      r_mod        <= r_mod_next;
      wait_cnt     <= cnt_next;
      resp_data    <= resp_data_next;
      resp_err     <= resp_err_next;
      acc_control  <= control_next;
      acc_start    <= (state_next == ISSUE) || (state_next == RS_ISSUE);
      cmd_ready    <= (state_next == IDLE);
      resp_valid   <= (state_next == RESP);
      busy         <= (state_next != IDLE);
      if (load_cmd) begin
        acc_a        <= cmd_a;
        acc_b        <= cmd_b;
        acc_modulant <= cmd_mod;
      end
    end
  end

endmodule
